// File: rtl/mult_operand_feeder.sv
// Operand feeder for the MAC pipe: issues x[col] reads for incoming nonzeros and
// pairs in-order read responses with queued {row, value} entries in FloPoCo format.
module mult_operand_feeder #(
  parameter int unsigned ROW_WIDTH  = 10,
  parameter int unsigned COL_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 48,
  parameter int unsigned FIFO_LOG2  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROW_WIDTH-1:0]  in_row,
  input  logic [COL_WIDTH-1:0]  in_col,
  input  logic [63:0]           in_val,
  input  logic [ADDR_WIDTH-1:0] vec_base,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_stall,
  input  logic                  mem_rsp_push,
  input  logic [63:0]           mem_rsp_data,
  output logic                  push_out,
  output logic [ROW_WIDTH-1:0]  row_out,
  output logic [65:0]           v0_out,
  output logic [65:0]           v1_out,
  output logic                  idle,
  output logic                  err_underflow
);

  localparam int unsigned DEPTH   = 1 << FIFO_LOG2;
  localparam int unsigned PTR_W   = FIFO_LOG2 + 1;
  localparam int unsigned FP_W    = 66;
  localparam int unsigned ENTRY_W = ROW_WIDTH + FP_W;

  // IEEE double to FloPoCo: prepend the 2-bit exception field, keep raw bits.
  function automatic logic [FP_W-1:0] to_flopoco(input logic [63:0] d);
    logic [10:0] e;
    logic [51:0] f;
    logic [1:0]  exn;
    e = d[62:52];
    f = d[51:0];
    if (e == 11'h000) begin
      exn = 2'b00;
    end else if (e == 11'h7FF) begin
      exn = (f == 52'd0) ? 2'b10 : 2'b11;
    end else begin
      exn = 2'b01;
    end
    return {exn, d};
  endfunction

  logic [ENTRY_W-1:0]    fifo_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  push_q, push_d;
  logic [ROW_WIDTH-1:0]  row_q, row_d;
  logic [FP_W-1:0]       v0_q, v0_d;
  logic [FP_W-1:0]       v1_q, v1_d;
  logic                  err_q, err_d;
  logic                  idle_q, idle_d;

  logic [PTR_W-1:0]      outstanding_c;
  logic [PTR_W-1:0]      outstanding_nxt_c;
  logic                  accept_c;
  logic                  pop_c;
  logic [ENTRY_W-1:0]    head_c;

  // Outstanding count is the pointer distance; full at DEPTH thanks to the extra wrap bit.
  assign outstanding_c = wr_ptr_q - rd_ptr_q;
  assign in_ready      = !rst && !mem_stall && (outstanding_c < PTR_W'(DEPTH));
  assign accept_c      = in_valid && in_ready;
  assign pop_c         = mem_rsp_push && (outstanding_c != '0);
  assign head_c        = fifo_q[rd_ptr_q[FIFO_LOG2-1:0]];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_req_d  = accept_c;
    mem_addr_d = mem_addr_q;
    push_d     = pop_c;
    row_d      = row_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    err_d      = err_q;
    if (accept_c) begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      mem_addr_d = vec_base + (ADDR_WIDTH'(in_col) << 3);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      row_d    = head_c[ENTRY_W-1:FP_W];
      v0_d     = head_c[FP_W-1:0];
      v1_d     = to_flopoco(mem_rsp_data);
    end
    if (mem_rsp_push && (outstanding_c == '0)) begin
      err_d = 1'b1;
    end
    outstanding_nxt_c = wr_ptr_d - rd_ptr_d;
    idle_d            = (outstanding_nxt_c == '0) && !mem_req_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      push_q     <= 1'b0;
      row_q      <= '0;
      v0_q       <= '0;
      v1_q       <= '0;
      err_q      <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      push_q     <= push_d;
      row_q      <= row_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      err_q      <= err_d;
      idle_q     <= idle_d;
    end
  end

  // Pending-entry storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      fifo_q[wr_ptr_q[FIFO_LOG2-1:0]] <= {in_row, to_flopoco(in_val)};
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign push_out      = push_q;
  assign row_out       = row_q;
  assign v0_out        = v0_q;
  assign v1_out        = v1_q;
  assign idle          = idle_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_mult_operand_feeder.sv
// Self-checking bench for mult_operand_feeder: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_mult_operand_feeder;
  localparam int unsigned RW = 10;
  localparam int unsigned CW = 32;
  localparam int unsigned AW = 48;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_row;
  logic [CW-1:0] in_col;
  logic [63:0]   in_val;
  logic [AW-1:0] vec_base;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_stall;
  logic          mem_rsp_push;
  logic [63:0]   mem_rsp_data;
  logic          push_out;
  logic [RW-1:0] row_out;
  logic [65:0]   v0_out;
  logic [65:0]   v1_out;
  logic          idle;
  logic          err_underflow;

  mult_operand_feeder #(
    .ROW_WIDTH(RW), .COL_WIDTH(CW), .ADDR_WIDTH(AW), .FIFO_LOG2(5)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .in_col(in_col), .in_val(in_val), .vec_base(vec_base),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_stall(mem_stall),
    .mem_rsp_push(mem_rsp_push), .mem_rsp_data(mem_rsp_data),
    .push_out(push_out), .row_out(row_out), .v0_out(v0_out), .v1_out(v1_out),
    .idle(idle), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference conversion from the format rules, using field arithmetic.
  function automatic logic [65:0] ref_conv(input logic [63:0] d);
    longint unsigned ex;
    longint unsigned man;
    logic [1:0] k;
    ex  = (d >> 52) % 2048;
    man = d % (64'd1 << 52);
    if (ex == 0) k = 2'd0;
    else if (ex == 2047) k = (man == 0) ? 2'd2 : 2'd3;
    else k = 2'd1;
    return {k, d};
  endfunction

  function automatic logic [63:0] rnd_double();
    logic [63:0] d;
    d = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: d[62:52] = 11'h000;
      1: d[62:52] = 11'h7FF;
      2: begin d[62:52] = 11'h7FF; d[51:0] = '0; end
      default: ;
    endcase
    return d;
  endfunction

  task automatic one_txn(input logic [RW-1:0] row, input logic [CW-1:0] col,
                         input logic [AW-1:0] base, input logic [63:0] val,
                         input logic [63:0] rsp, input logic [65:0] ev0,
                         input logic [65:0] ev1, input logic [AW-1:0] eaddr);
    in_valid = 1'b1; in_row = row; in_col = col; in_val = val; vec_base = base;
    #1 chk("txn_ready", 128'(in_ready), 128'(1'b1));
    step();
    in_valid = 1'b0;
    chk("txn_mem_req", 128'(mem_req), 128'(1'b1));
    chk("txn_mem_addr", 128'(mem_addr), 128'(eaddr));
    chk("txn_idle_busy", 128'(idle), 128'(1'b0));
    mem_rsp_push = 1'b1; mem_rsp_data = rsp;
    step();
    mem_rsp_push = 1'b0;
    chk("txn_push", 128'(push_out), 128'(1'b1));
    chk("txn_row", 128'(row_out), 128'(row));
    chk("txn_v0", 128'(v0_out), 128'(ev0));
    chk("txn_v1", 128'(v1_out), 128'(ev1));
    step();
    chk("txn_push_end", 128'(push_out), 128'(1'b0));
    chk("txn_idle_end", 128'(idle), 128'(1'b1));
  endtask

  typedef struct {
    logic [63:0] val;
    logic [63:0] rsp;
    logic [65:0] v0;
    logic [65:0] v1;
  } conv_vec_t;

  conv_vec_t tbl [4];

  initial begin
    int acc_cnt;
    tbl[0] = '{64'h8000000000000000, 64'h0000000000000001, 66'h0_8000000000000000, 66'h0_0000000000000001};
    tbl[1] = '{64'h7FF0000000000000, 64'h7FF8000000000000, 66'h2_7FF0000000000000, 66'h3_7FF8000000000000};
    tbl[2] = '{64'h3FF0000000000000, 64'hC000000000000000, 66'h1_3FF0000000000000, 66'h1_C000000000000000};
    tbl[3] = '{64'hFFF0000000000000, 64'h000FFFFFFFFFFFFF, 66'h2_FFF0000000000000, 66'h0_000FFFFFFFFFFFFF};

    rst = 1'b1; in_valid = 1'b0; in_row = '0; in_col = '0; in_val = '0; vec_base = '0;
    mem_stall = 1'b0; mem_rsp_push = 1'b0; mem_rsp_data = '0;
    in_valid = 1'b1;
    repeat (3) step();
    chk("rst_in_ready", 128'(in_ready), 128'(1'b0));
    chk("rst_mem_req", 128'(mem_req), 128'(1'b0));
    chk("rst_push", 128'(push_out), 128'(1'b0));
    chk("rst_err", 128'(err_underflow), 128'(1'b0));
    chk("rst_idle", 128'(idle), 128'(1'b1));
    chk("rst_addr", 128'(mem_addr), 128'(0));
    chk("rst_vals", 128'({row_out, v0_out, v1_out}), 128'(0));
    in_valid = 1'b0;
    rst = 1'b0;
    step();

    // Single nonzero
    one_txn(10'd7, 32'd5, 48'h1000, 64'h3FF0000000000000, 64'h4000000000000000,
            66'h1_3FF0000000000000, 66'h1_4000000000000000, 48'h1028);

    // Conversion corners
    for (int i = 0; i < 4; i++) begin
      one_txn(RW'(i + 1), CW'(i), '0, tbl[i].val, tbl[i].rsp, tbl[i].v0, tbl[i].v1,
              AW'(i) << 3);
    end

    // Address wraps mod 2^48
    one_txn(10'd9, 32'hFFFF_FFFF, 48'hFFFF_FFFF_FFF0, 64'h3FF0000000000000, 64'h3FF0000000000000,
            66'h1_3FF0000000000000, 66'h1_3FF0000000000000, 48'h0007_FFFF_FFE8);

    // Credit full
    acc_cnt = 0;
    in_val = 64'h4008000000000000;
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1; in_row = RW'(acc_cnt);
      #1;
      if (in_ready) acc_cnt++;
      step();
    end
    chk("full_accepts", 128'(acc_cnt), 128'(32));
    chk("full_not_ready", 128'(in_ready), 128'(1'b0));
    in_row = RW'(acc_cnt);
    mem_rsp_push = 1'b1; mem_rsp_data = 64'h3FF0000000000000;
    #1 chk("full_ready_rsp_cycle", 128'(in_ready), 128'(1'b0));
    step();
    mem_rsp_push = 1'b0;
    chk("full_push0", 128'(push_out), 128'(1'b1));
    chk("full_row0", 128'(row_out), 128'(0));
    chk("full_v0_0", 128'(v0_out), 128'(66'h1_4008000000000000));
    chk("full_ready_after", 128'(in_ready), 128'(1'b1));
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      mem_rsp_push = 1'b1;
      step();
      mem_rsp_push = 1'b0;
      chk("full_drain_push", 128'(push_out), 128'(1'b1));
      chk("full_drain_row", 128'(row_out), 128'(k));
    end
    step();
    chk("full_idle", 128'(idle), 128'(1'b1));

    // Stall
    in_valid = 1'b1; in_row = 10'd3; mem_stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 chk("stall_ready", 128'(in_ready), 128'(1'b0));
      step();
      chk("stall_no_req", 128'(mem_req), 128'(1'b0));
    end
    mem_stall = 1'b0;
    #1 chk("stall_release_ready", 128'(in_ready), 128'(1'b1));
    step();
    in_valid = 1'b0;
    chk("stall_release_req", 128'(mem_req), 128'(1'b1));
    mem_rsp_push = 1'b1;
    step();
    mem_rsp_push = 1'b0;
    chk("stall_push", 128'(push_out), 128'(1'b1));
    chk("stall_row", 128'(row_out), 128'(3));
    step();

    // Underflow
    mem_rsp_push = 1'b1;
    step();
    mem_rsp_push = 1'b0;
    chk("uf_err", 128'(err_underflow), 128'(1'b1));
    chk("uf_no_push", 128'(push_out), 128'(1'b0));
    repeat (3) step();
    chk("uf_sticky", 128'(err_underflow), 128'(1'b1));
    rst = 1'b1;
    step();
    mem_rsp_push = 1'b1;
    step();
    mem_rsp_push = 1'b0;
    rst = 1'b0;
    step();
    chk("uf_cleared", 128'(err_underflow), 128'(1'b0));

    // Randomized ordering run
    begin
      logic [RW-1:0] exp_row_q [$];
      logic [63:0]   exp_val_q [$];
      logic [63:0]   rsp_q [$];
      int            due_q [$];
      int            cyc;
      int            acc_n;
      int            out_m;
      bit            last_acc;
      bit            stall;
      bit            rsp;
      bit            vld;
      bit            ready_exp;
      logic [AW-1:0] last_addr;
      logic [63:0]   sum;
      logic [RW-1:0] r_row;
      logic [63:0]   r_val;
      logic [63:0]   r_rsp;
      cyc = 0; acc_n = 0; out_m = 0; last_acc = 1'b0; last_addr = '0;
      while (cyc < 20000) begin
        chk("rnd_mem_req", 128'(mem_req), 128'(last_acc));
        if (mem_req && last_acc) begin
          chk("rnd_mem_addr", 128'(mem_addr), 128'(last_addr));
          due_q.push_back(cyc + int'($urandom_range(1, 40)));
        end
        if (push_out) begin
          if (exp_row_q.size() == 0 || rsp_q.size() == 0) begin
            n_total++;
            $display("FAIL rnd_push_extra: got push_out=1 expected no pending entry");
          end else begin
            r_row = exp_row_q.pop_front();
            r_val = exp_val_q.pop_front();
            r_rsp = rsp_q.pop_front();
            chk("rnd_row", 128'(row_out), 128'(r_row));
            chk("rnd_v0", 128'(v0_out), 128'(ref_conv(r_val)));
            chk("rnd_v1", 128'(v1_out), 128'(ref_conv(r_rsp)));
          end
        end
        if (acc_n >= 200 && out_m == 0 && due_q.size() == 0 && !push_out) break;
        stall = ($urandom_range(0, 7) == 0);
        rsp = (due_q.size() > 0) && (due_q[0] <= cyc);
        mem_rsp_push = rsp;
        if (rsp) begin
          void'(due_q.pop_front());
          mem_rsp_data = rnd_double();
          rsp_q.push_back(mem_rsp_data);
        end
        vld = (acc_n < 200) && ($urandom_range(0, 3) != 0);
        in_valid = vld; mem_stall = stall;
        in_row = RW'($urandom); in_col = $urandom; in_val = rnd_double();
        vec_base = AW'({$urandom, $urandom});
        ready_exp = !stall && (out_m < 32);
        #1 chk("rnd_ready", 128'(in_ready), 128'(ready_exp));
        last_acc = vld && ready_exp;
        if (last_acc) begin
          exp_row_q.push_back(in_row);
          exp_val_q.push_back(in_val);
          sum = {16'd0, vec_base} + {29'd0, in_col, 3'd0};
          last_addr = sum[AW-1:0];
          acc_n++;
        end
        out_m = out_m + int'(last_acc) - int'(rsp);
        step();
        mem_rsp_push = 1'b0;
        cyc++;
      end
      in_valid = 1'b0; mem_stall = 1'b0;
      step();
      chk("rnd_accepts", 128'(acc_n), 128'(200));
      chk("rnd_all_pushed", 128'(exp_row_q.size()), 128'(0));
      chk("rnd_idle", 128'(idle), 128'(1'b1));
      chk("rnd_no_err", 128'(err_underflow), 128'(1'b0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
